// File: rtl/cpu_hazard_pkg.sv
// Shared encodings for the decoder's hazard optype and the ID-stage forward selects.
// Both sets of codes are also used by the decoder and the ID-stage operand muxes.
package cpu_hazard_pkg;

    typedef enum logic [1:0] {
        NO_HAZ  = 2'b00,
        ALU_HAZ = 2'b01,
        LD_HAZ  = 2'b10,
        SD_HAZ  = 2'b11
    } hazard_optype_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'd0,
        FWD_EXE_ALU = 2'd1,
        FWD_MEM_ALU = 2'd2,
        FWD_MEM_LD  = 2'd3
    } fwd_sel_e;

    // Only ALU and load instructions write a register, and x0 is never a producer.
    function automatic logic writes_rd(input logic [1:0] optype, input logic rd_nonzero);
        return rd_nonzero && (optype == ALU_HAZ || optype == LD_HAZ);
    endfunction

endpackage

// File: rtl/hazard_track_slot.sv
// One pipeline tracker slot: holds {optype, rd, rs2} of the instruction in a stage.
// Asserting bubble loads an all-zero entry instead of the incoming one.
module hazard_track_slot #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic [1:0]        optype_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [REG_AW-1:0] rs2_in,
    output logic [1:0]        optype,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs2
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            optype <= '0;
            rd     <= '0;
            rs2    <= '0;
        end else if (bubble) begin
            optype <= '0;
            rd     <= '0;
            rs2    <= '0;
        end else begin
            optype <= optype_in;
            rd     <= rd_in;
            rs2    <= rs2_in;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard unit: tracks EXE/MEM/WB producers and drives operand forwarding,
// store-data forwarding, load-use stall and branch flush controls.
module hazard_detection_unit
    import cpu_hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_addr_ID,
    input  logic [REG_AW-1:0] rs2_addr_ID,
    input  logic [REG_AW-1:0] rd_addr_ID,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [1:0]        hazard_optype_ID,
    input  logic              Branch_ID,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush
);

    logic [1:0]        exe_op, mem_op, wb_op;
    logic [REG_AW-1:0] exe_rd, mem_rd, wb_rd;
    logic [REG_AW-1:0] exe_rs2, mem_rs2, unused_wb_rs2;
    logic              stall;

    hazard_track_slot #(.REG_AW(REG_AW)) u_slot_exe (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble    (stall),
        .optype_in (hazard_optype_ID),
        .rd_in     (rd_addr_ID),
        .rs2_in    (rs2_addr_ID),
        .optype    (exe_op),
        .rd        (exe_rd),
        .rs2       (exe_rs2)
    );

    hazard_track_slot #(.REG_AW(REG_AW)) u_slot_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble    (1'b0),
        .optype_in (exe_op),
        .rd_in     (exe_rd),
        .rs2_in    (exe_rs2),
        .optype    (mem_op),
        .rd        (mem_rd),
        .rs2       (mem_rs2)
    );

    hazard_track_slot #(.REG_AW(REG_AW)) u_slot_wb (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble    (1'b0),
        .optype_in (mem_op),
        .rd_in     (mem_rd),
        .rs2_in    (mem_rs2),
        .optype    (wb_op),
        .rd        (wb_rd),
        .rs2       (unused_wb_rs2)
    );

    // EXE is checked first so the youngest producer wins; an EXE load falls through to MEM.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_AW-1:0] src);
        logic exe_hit, mem_hit;
        exe_hit = use_src && writes_rd(exe_op, exe_rd != '0) && (exe_rd == src);
        mem_hit = use_src && writes_rd(mem_op, mem_rd != '0) && (mem_rd == src);
        if (exe_hit && exe_op == ALU_HAZ) return FWD_EXE_ALU;
        if (mem_hit && mem_op == ALU_HAZ) return FWD_MEM_ALU;
        if (mem_hit && mem_op == LD_HAZ)  return FWD_MEM_LD;
        return FWD_REG;
    endfunction

    logic exe_load, rs1_match, rs2_match;

    always_comb begin
        exe_load  = (exe_op == LD_HAZ) && (exe_rd != '0);
        rs1_match = rs1use_ID && (rs1_addr_ID == exe_rd);
        rs2_match = rs2use_ID && (rs2_addr_ID == exe_rd);
        // A store only needing the load result as store data picks it up in MEM instead.
        stall = exe_load && (rs1_match || (rs2_match && hazard_optype_ID != SD_HAZ));
    end

    always_comb begin
        forward_ctrl_A  = fwd_sel(rs1use_ID, rs1_addr_ID);
        forward_ctrl_B  = fwd_sel(rs2use_ID, rs2_addr_ID);
        forward_ctrl_ls = (mem_op == SD_HAZ) && (wb_op == LD_HAZ) && (wb_rd != '0)
                          && (wb_rd == mem_rs2);
        PC_EN_IF        = ~stall;
        reg_FD_EN       = ~stall;
        reg_DE_flush    = stall;
        reg_FD_flush    = Branch_ID & ~stall;
    end

endmodule
